uart_key_echo_hub: RTL and testbench
====================================

Name: uart_key_echo_hub

Overview:
Parametrised UART front-panel controller. It sits between the debounced key bank, the byte-level UART core and the 7-segment display driver.
- Converts key presses into code bytes and optionally echoes received bytes.
- Queues all outgoing bytes in a TX FIFO so that no key press is lost.
- Keeps a configurable-depth history of received bytes for display.
- Replaces the level-triggered, unqueued send logic of the previous-generation top level.

Parameters:
NUM_KEYS, 4, number of active-low debounced key inputs (1..8)
HIST_DEPTH, 3, number of received bytes kept in history (1..8)
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
KEY_CODE_BASE, 8'h11, code byte for key 0
KEY_CODE_STEP, 8'h11, code increment per key index (8-bit wrap)
ARM_TIMEOUT, 15, cycles to wait for tx_busy rise after tx_send

Ports:
sys_clk  in  1  system clock; the block's only clock
sys_rst_n  in  1  reset, synchronous, active-low
key_stable  in  NUM_KEYS  debounced keys, 0 = pressed
echo_en  in  1  1 = echo each received byte back
rx_valid  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received byte
tx_busy  in  1  UART transmitter busy
tx_send  out  1  one-cycle send strobe
tx_data  out  8  byte to transmit, stable from tx_send until next pop
hist_data  out  8*HIST_DEPTH  [7:0] = newest received byte
fifo_count  out  $clog2(FIFO_DEPTH+1)  TX FIFO occupancy
overflow  out  1  sticky; an echo byte was dropped
rx_count  out  16  received-byte counter (optional feature)
tx_count  out  16  sent-byte counter (optional feature)

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge) clears all outputs, history, FIFO, pending flags, counters and the key-edge registers; FSM goes to IDLE. Reset mid-transmission abandons the byte; tx_send stays 0.
- Key press detection:
  - Press = key_stable[i] 1->0 on registered samples; key-edge registers reset to all-1.
  - A press sets pending[i]. Holding a key produces no repeats; a second press while pending[i]=1 is absorbed.
- Enqueue arbitration, at most one FIFO write per cycle:
  - Echo has top priority: rx_valid & echo_en.
  - Otherwise, the lowest-index pending key.
  - Key code = KEY_CODE_BASE + i*KEY_CODE_STEP (mod 256).
- FIFO full:
  - An echo request is dropped and sets overflow; overflow clears only on reset.
  - A key request stays pending until space frees. Keys are never dropped.
- Simultaneous push and pop on a full FIFO is allowed; the pop frees the slot in the same cycle.
- History: on every rx_valid, regardless of echo_en, shift by one byte; the new byte goes into [7:0] and the oldest is discarded. Visible the cycle after rx_valid.
- TX FSM:
  - IDLE: if FIFO is non-empty and tx_busy=0, pop, register tx_data = head, pulse tx_send for 1 cycle, go to ARM.
  - ARM: if tx_busy=1, go to DRAIN; if ARM_TIMEOUT cycles elapse with no rise, go to IDLE (byte counted as sent).
  - DRAIN: when tx_busy=0, go to IDLE.
- Minimum interval between tx_send pulses: 3 cycles.
- Latency: a key press, or an echo into an empty FIFO with an idle transmitter, gives tx_send 2 cycles after the edge/rx_valid.
- fifo_count is registered; it updates the cycle after a push or pop.

Optional Feature:
UART_HUB_STATS_EN
- Defined: rx_count increments on each rx_valid; tx_count increments on each tx_send. Both are 16-bit and wrap at 16'hFFFF -> 0.
- Undefined: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Package uart_hub_pkg:
  - FSM state enum (IDLE, ARM, DRAIN)
  - byte typedef
  - default key-code constants
- Sub-module sync_byte_fifo:
  - synchronous FIFO, parameter DEPTH
  - ports: push/din, pop/dout, full, empty, count
  - same sys_clk and synchronous active-low sys_rst_n

Test Plan:
- Press key 2 once (hold 50 cycles), tx_busy model 10 cycles -> exactly one tx_send with tx_data=8'h33; no repeat while held.
- echo_en=1, rx_valid with 8'hA5, then 8'h5A, then 8'h3C -> hist_data=24'hA55A3C (oldest..newest); tx_data sequence A5, 5A, 3C.
- rx_valid 8'h77 with echo_en=1 in the same cycle as key 0 and key 3 presses -> send order 77, 11, 44.
- Hold tx_busy=1, inject 10 echo bytes 8'h01..8'h0A -> fifo_count=8, overflow=1; release -> bytes 01..08 sent, 09 and 0A absent.
- tx_busy stuck 0 after tx_send -> FSM returns to IDLE after 15 cycles and the next queued byte is sent.
- Assert sys_rst_n=0 for 1 cycle in DRAIN with 3 bytes queued -> fifo_count=0, hist_data=0, overflow=0, no further tx_send.

Source files
------------

// File: rtl/uart_hub_pkg.sv
// Shared types and default key-code constants for the UART front-panel hub.
package uart_hub_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_DRAIN = 2'd2
    } tx_state_e;

    localparam byte_t DEF_KEY_CODE_BASE = 8'h11;
    localparam byte_t DEF_KEY_CODE_STEP = 8'h11;

endpackage

// File: rtl/sync_byte_fifo.sv
// Synchronous byte FIFO (power-of-two DEPTH); a pop on a full FIFO frees the
// slot for a push in the same cycle.
module sync_byte_fifo
    import uart_hub_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst_n,
    input  logic                         push,
    input  logic [7:0]                   din,
    input  logic                         pop,
    output logic [7:0]                   dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    byte_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;
    logic [CNT_W-1:0] count_nx_c;

    always_comb begin
        pop_ok_c   = pop && !empty;
        push_ok_c  = push && (!full || pop_ok_c);
        count_nx_c = count;
        if (push_ok_c && !pop_ok_c) begin
            count_nx_c = count + CNT_W'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            count_nx_c = count - CNT_W'(1);
        end
    end

    // Flags are registered alongside the count so they never glitch.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nx_c;
            full  <= (count_nx_c == CNT_W'(DEPTH));
            empty <= (count_nx_c == CNT_W'(0));
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok_c) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_key_echo_hub.sv
// UART front-panel hub: key presses and echoed RX bytes are queued to the UART,
// and recent RX bytes are kept for display. Build macro UART_HUB_STATS_EN adds byte counters.
module uart_key_echo_hub
    import uart_hub_pkg::*;
#(
    parameter int unsigned NUM_KEYS      = 4,
    parameter int unsigned HIST_DEPTH    = 3,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter byte_t       KEY_CODE_BASE = DEF_KEY_CODE_BASE,
    parameter byte_t       KEY_CODE_STEP = DEF_KEY_CODE_STEP,
    parameter int unsigned ARM_TIMEOUT   = 15
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic [NUM_KEYS-1:0]                key_stable,
    input  logic                               echo_en,
    input  logic                               rx_valid,
    input  logic [7:0]                         rx_data,
    input  logic                               tx_busy,
    output logic                               tx_send,
    output logic [7:0]                         tx_data,
    output logic [8*HIST_DEPTH-1:0]            hist_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               overflow,
    output logic [15:0]                        rx_count,
    output logic [15:0]                        tx_count
);

    localparam int unsigned ARM_W = $clog2(ARM_TIMEOUT + 1);

    logic [NUM_KEYS-1:0] key_q;
    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] press_c;
    logic [NUM_KEYS-1:0] req_c;
    logic [NUM_KEYS-1:0] grant_c;
    logic                key_hit_c;
    logic                echo_req_c;
    logic                room_c;
    logic                push_c;
    logic                pop_c;
    logic                key_taken_c;
    byte_t               key_code_c;
    byte_t               din_c;
    byte_t               fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;
    tx_state_e           state;
    logic [ARM_W-1:0]    arm_cnt;

    // Falling-edge press detect and lowest-index pick among requesting keys.
    always_comb begin
        press_c    = key_q & ~key_stable;
        req_c      = pending | press_c;
        grant_c    = '0;
        key_hit_c  = 1'b0;
        key_code_c = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            if (req_c[i] && !key_hit_c) begin
                key_hit_c  = 1'b1;
                grant_c[i] = 1'b1;
                key_code_c = KEY_CODE_BASE + 8'(i) * KEY_CODE_STEP;
            end
        end
    end

    // Echo wins the single write port; a pop this cycle counts as free space.
    always_comb begin
        pop_c       = (state == ST_IDLE) && !fifo_empty && !tx_busy;
        room_c      = !fifo_full || pop_c;
        echo_req_c  = rx_valid && echo_en;
        key_taken_c = !echo_req_c && key_hit_c && room_c;
        push_c      = (echo_req_c || key_hit_c) && room_c;
        din_c       = echo_req_c ? rx_data : key_code_c;
    end

    sync_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (push_c),
        .din       (din_c),
        .pop       (pop_c),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            key_q    <= '1;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            key_q   <= key_stable;
            pending <= req_c & ~({NUM_KEYS{key_taken_c}} & grant_c);
            if (echo_req_c && !room_c) overflow <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hist_data <= '0;
        end else if (rx_valid) begin
            for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
                hist_data[i*BYTE_W +: BYTE_W] <= hist_data[(i-1)*BYTE_W +: BYTE_W];
            end
            hist_data[BYTE_W-1:0] <= rx_data;
        end
    end

    // ARM waits for the UART to acknowledge by raising busy; a missing ack times out.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state   <= ST_IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
            arm_cnt <= '0;
        end else begin
            tx_send <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        tx_send <= 1'b1;
                        tx_data <= fifo_dout;
                        arm_cnt <= '0;
                        state   <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (tx_busy) begin
                        state <= ST_DRAIN;
                    end else if (arm_cnt == ARM_W'(ARM_TIMEOUT - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        arm_cnt <= arm_cnt + ARM_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (!tx_busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_HUB_STATS_EN
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            if (rx_valid) rx_count <= rx_count + 16'd1;
            if (pop_c)    tx_count <= tx_count + 16'd1;
        end
    end
`else
    assign rx_count = '0;
    assign tx_count = '0;
`endif

endmodule

// File: tb/tb_uart_key_echo_hub.sv
// Self-checking bench for uart_key_echo_hub: directed scenarios plus randomized
// key/echo events checked against a queue-based model of the outgoing byte stream.
`timescale 1ns/1ps
module tb_uart_key_echo_hub;

    localparam int NUM_KEYS    = 4;
    localparam int HIST_DEPTH  = 3;
    localparam int FIFO_DEPTH  = 8;
    localparam int ARM_TIMEOUT = 15;
    localparam logic [7:0] KB  = 8'h11;
    localparam logic [7:0] KS  = 8'h11;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);

    logic                    sys_clk = 1'b0;
    logic                    sys_rst_n = 1'b0;
    logic [NUM_KEYS-1:0]     key_stable = '1;
    logic                    echo_en = 1'b0;
    logic                    rx_valid = 1'b0;
    logic [7:0]              rx_data = 8'h00;
    logic                    tx_busy = 1'b0;
    logic                    tx_send;
    logic [7:0]              tx_data;
    logic [8*HIST_DEPTH-1:0] hist_data;
    logic [CNT_W-1:0]        fifo_count;
    logic                    overflow;
    logic [15:0]             rx_count;
    logic [15:0]             tx_count;

    uart_key_echo_hub #(
        .NUM_KEYS      (NUM_KEYS),
        .HIST_DEPTH    (HIST_DEPTH),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .KEY_CODE_BASE (KB),
        .KEY_CODE_STEP (KS),
        .ARM_TIMEOUT   (ARM_TIMEOUT)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_stable (key_stable),
        .echo_en    (echo_en),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_busy    (tx_busy),
        .tx_send    (tx_send),
        .tx_data    (tx_data),
        .hist_data  (hist_data),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .rx_count   (rx_count),
        .tx_count   (tx_count)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] got_q[$];
    int         send_cyc_q[$];
    int         last_send = -1000;
    int         min_gap = 1000;
    int         sent_total = 0;
    int         tx_base = 0;
    int         rx_total = 0;
    logic [7:0] hist_m[HIST_DEPTH];

    int busy_mode = 0;   // 0: busy for busy_len cycles after each send, 1: forced high, 2: never busy
    int busy_len  = 10;
    int busy_left = 0;

    initial forever #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    initial forever begin
        @(negedge sys_clk);
        if (tx_send === 1'b1) begin
            got_q.push_back(tx_data);
            send_cyc_q.push_back(cyc);
            if (cyc - last_send < min_gap) min_gap = cyc - last_send;
            last_send = cyc;
            sent_total++;
        end
    end

    initial forever begin
        @(negedge sys_clk);
        if (busy_mode == 1) begin
            tx_busy = 1'b1;
        end else if (busy_mode == 2) begin
            tx_busy   = 1'b0;
            busy_left = 0;
        end else begin
            if (tx_send === 1'b1) busy_left = busy_len;
            if (busy_left > 0) begin
                tx_busy = 1'b1;
                busy_left--;
            end else begin
                tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] key_code(input int i);
        int v;
        v = (int'(KB) + i * int'(KS)) % 256;
        return 8'(v);
    endfunction

    function automatic logic [8*HIST_DEPTH-1:0] hist_exp();
        logic [8*HIST_DEPTH-1:0] v;
        v = '0;
        for (int i = 0; i < HIST_DEPTH; i++) v[i*8 +: 8] = hist_m[i];
        return v;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        send_cyc_q.delete();
    endtask

    task automatic clear_model();
        for (int i = 0; i < HIST_DEPTH; i++) hist_m[i] = 8'h00;
        rx_total = 0;
        tx_base  = sent_total;
        clear_mon();
    endtask

    // One cycle of stimulus; pressed keys stay held until the caller releases them.
    task automatic apply_event(input bit do_rx, input logic [7:0] d, input logic [NUM_KEYS-1:0] press);
        rx_valid   = do_rx;
        rx_data    = d;
        key_stable = ~press;
        if (do_rx) begin
            for (int i = HIST_DEPTH - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
            hist_m[0] = d;
            rx_total++;
        end
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while (got_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        clear_model();
        n_vec++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL reset_tx_send got=%b exp=0", tx_send); end
        n_vec++; if (fifo_count !== CNT_W'(0)) begin n_err++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
        n_vec++; if (hist_data !== '0) begin n_err++; $display("FAIL reset_hist got=%h exp=0", hist_data); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_vec++; if (rx_count !== 16'd0 || tx_count !== 16'd0) begin
            n_err++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", rx_count, tx_count);
        end
    endtask

    task automatic test_key_hold();
        int t0;
        busy_mode = 0; busy_len = 10; echo_en = 1'b0;
        clear_mon();
        t0 = cyc;
        apply_event(1'b0, 8'h00, NUM_KEYS'(4'b0100));
        tick(49);
        key_stable = '1;
        tick(20);
        n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL key_hold_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_vec++; if (got_q[0] !== key_code(2)) begin n_err++; $display("FAIL key_hold_data got=%02h exp=%02h", got_q[0], key_code(2)); end
            n_vec++; if (send_cyc_q[0] - t0 != 2) begin n_err++; $display("FAIL key_latency got=%0d exp=2", send_cyc_q[0] - t0); end
        end
    endtask

    task automatic test_echo_hist();
        logic [7:0] exp_b[3];
        int t0;
        bit ok;
        exp_b[0] = 8'hA5; exp_b[1] = 8'h5A; exp_b[2] = 8'h3C;
        busy_mode = 0; busy_len = 10; echo_en = 1'b1;
        clear_mon();
        t0 = cyc;
        for (int i = 0; i < 3; i++) apply_event(1'b1, exp_b[i], '0);
        n_vec++; if (hist_data !== 24'hA55A3C) begin n_err++; $display("FAIL echo_hist got=%h exp=a55a3c", hist_data); end
        wait_sent(3, 200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL echo_timeout got=%0d sends exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_b[i]) begin n_err++; $display("FAIL echo_order idx=%0d got=%02h exp=%02h", i, got_q[i], exp_b[i]); end
        end
        if (send_cyc_q.size() > 0) begin
            n_vec++; if (send_cyc_q[0] - t0 != 2) begin n_err++; $display("FAIL echo_latency got=%0d exp=2", send_cyc_q[0] - t0); end
        end
        tick(20);
    endtask

    task automatic test_priority();
        logic [7:0] exp_q[$];
        bit ok;
        busy_mode = 0; busy_len = 10; echo_en = 1'b1;
        clear_mon();
        exp_q.push_back(8'h77);
        exp_q.push_back(key_code(0));
        exp_q.push_back(key_code(3));
        apply_event(1'b1, 8'h77, NUM_KEYS'(4'b1001));
        tick(2);
        key_stable = '1;
        wait_sent(3, 200, ok);
        tick(20);
        n_vec++; if (got_q.size() != 3) begin n_err++; $display("FAIL prio_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL prio_order idx=%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        bit ok;
        bit ovf_m;
        ovf_m = 1'b0;
        echo_en = 1'b1;
        busy_mode = 1;
        tick(3);
        clear_mon();
        for (int i = 1; i <= 10; i++) begin
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(8'(i));
            else ovf_m = 1'b1;
            apply_event(1'b1, 8'(i), '0);
        end
        tick(2);
        n_vec++; if (fifo_count !== CNT_W'(FIFO_DEPTH)) begin n_err++; $display("FAIL ovf_fifo_count got=%0d exp=%0d", fifo_count, FIFO_DEPTH); end
        n_vec++; if (overflow !== ovf_m) begin n_err++; $display("FAIL ovf_flag got=%b exp=%b", overflow, ovf_m); end
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL ovf_early_send got=%0d exp=0", got_q.size()); end
        n_vec++; if (hist_data !== hist_exp()) begin n_err++; $display("FAIL ovf_hist got=%h exp=%h", hist_data, hist_exp()); end
        busy_mode = 0; busy_len = 4;
        wait_sent(exp_q.size(), 600, ok);
        tick(50);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL ovf_sent_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovf_order idx=%0d got=%02h exp=%02h", i, got_q[i], exp_q[i]); end
        end
        n_vec++; if (fifo_count !== CNT_W'(0)) begin n_err++; $display("FAIL ovf_drained got=%0d exp=0", fifo_count); end
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_timeout();
        bit ok;
        int gap;
        busy_mode = 2; echo_en = 1'b1;
        clear_mon();
        apply_event(1'b1, 8'hA1, '0);
        apply_event(1'b1, 8'hB2, '0);
        wait_sent(2, 100, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL timeout_stall got=%0d sends exp=2", got_q.size()); end
        if (got_q.size() >= 2) begin
            gap = send_cyc_q[1] - send_cyc_q[0];
            n_vec++; if (got_q[0] !== 8'hA1 || got_q[1] !== 8'hB2) begin
                n_err++; $display("FAIL timeout_data got=%02h,%02h exp=a1,b2", got_q[0], got_q[1]);
            end
            n_vec++; if (gap < ARM_TIMEOUT + 1 || gap > ARM_TIMEOUT + 2) begin
                n_err++; $display("FAIL timeout_gap got=%0d exp=%0d..%0d", gap, ARM_TIMEOUT + 1, ARM_TIMEOUT + 2);
            end
        end
        tick(ARM_TIMEOUT + 5);
        busy_mode = 0;
        tick(2);
    endtask

    task automatic test_back_to_back();
        bit ok;
        busy_mode = 0; busy_len = 1; echo_en = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) apply_event(1'b1, 8'(8'hD0 + i), '0);
        wait_sent(4, 200, ok);
        tick(10);
        n_vec++; if (got_q.size() != 4) begin n_err++; $display("FAIL b2b_count got=%0d exp=4", got_q.size()); end
        for (int i = 1; i < send_cyc_q.size(); i++) begin
            n_vec++; if (send_cyc_q[i] - send_cyc_q[i-1] < 3) begin
                n_err++; $display("FAIL b2b_gap idx=%0d got=%0d exp>=3", i, send_cyc_q[i] - send_cyc_q[i-1]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        logic [NUM_KEYS-1:0] press;
        bit do_rx;
        bit ok;
        for (int it = 0; it < 40; it++) begin
            exp_q.delete();
            clear_mon();
            busy_mode = 0;
            busy_len  = int'($urandom_range(1, 12));
            echo_en   = 1'($urandom_range(0, 1));
            do_rx     = ($urandom_range(0, 3) != 0);
            d         = 8'($urandom);
            press     = NUM_KEYS'($urandom);
            if (!do_rx && press == '0) press = NUM_KEYS'(1 << $urandom_range(0, NUM_KEYS - 1));
            if (do_rx && echo_en) exp_q.push_back(d);
            for (int k = 0; k < NUM_KEYS; k++) if (press[k]) exp_q.push_back(key_code(k));
            apply_event(do_rx, d, press);
            tick(int'($urandom_range(1, 20)));
            key_stable = '1;
            wait_sent(exp_q.size(), 600, ok);
            tick(20);
            n_vec++; if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                n_vec++; if (got_q[i] !== exp_q[i]) begin
                    n_err++; $display("FAIL rand_byte it=%0d idx=%0d got=%02h exp=%02h", it, i, got_q[i], exp_q[i]);
                end
            end
            n_vec++; if (hist_data !== hist_exp()) begin n_err++; $display("FAIL rand_hist it=%0d got=%h exp=%h", it, hist_data, hist_exp()); end
        end
    endtask

    task automatic test_stats();
        logic [15:0] exp_rx;
        logic [15:0] exp_tx;
`ifdef UART_HUB_STATS_EN
        exp_rx = 16'(rx_total);
        exp_tx = 16'(sent_total - tx_base);
`else
        exp_rx = 16'd0;
        exp_tx = 16'd0;
`endif
        n_vec++; if (rx_count !== exp_rx) begin n_err++; $display("FAIL stats_rx got=%0d exp=%0d", rx_count, exp_rx); end
        n_vec++; if (tx_count !== exp_tx) begin n_err++; $display("FAIL stats_tx got=%0d exp=%0d", tx_count, exp_tx); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        busy_mode = 0; busy_len = 20; echo_en = 1'b1;
        clear_mon();
        for (int i = 0; i < 4; i++) apply_event(1'b1, 8'(8'hC1 + i), '0);
        wait_sent(1, 50, ok);
        tick(3);
        n_vec++; if (fifo_count !== CNT_W'(3)) begin n_err++; $display("FAIL rstmid_pre_count got=%0d exp=3", fifo_count); end
        sys_rst_n = 1'b0;
        tick(1);
        sys_rst_n = 1'b1;
        clear_model();
        n_vec++; if (tx_send !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_send got=%b exp=0", tx_send); end
        n_vec++; if (fifo_count !== CNT_W'(0)) begin n_err++; $display("FAIL rstmid_fifo_count got=%0d exp=0", fifo_count); end
        n_vec++; if (hist_data !== '0) begin n_err++; $display("FAIL rstmid_hist got=%h exp=0", hist_data); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
        tick(60);
        n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL rstmid_extra_send got=%0d exp=0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_key_hold();
        test_echo_hist();
        test_priority();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_random();
        test_stats();
        n_vec++; if (min_gap < 3) begin n_err++; $display("FAIL min_send_gap got=%0d exp>=3", min_gap); end
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
